// File: rtl/up_pack_pkg.sv
// up_pack_pkg: shared types and helpers for the narrow-write to 64-bit phrase packer.
//   - beat size codes (byte / word / long)
//   - align_off / lane_mask: size alignment and byte-lane enable generation
//   - phrase_t: one 64-bit phrase with byte enables and phrase address
//   - flush_st_e: state of the deferred-flush tracker
package up_pack_pkg;

    localparam logic [1:0] SIZ_BYTE = 2'd0;
    localparam logic [1:0] SIZ_WORD = 2'd1;
    localparam logic [1:0] SIZ_LONG = 2'd2;

    // Widest phrase address carried in phrase_t; the top uses the low ADDR_W bits.
    localparam int unsigned PADDR_MAX_W = 32;

    typedef struct packed {
        logic [63:0]            data;
        logic [7:0]             be;
        logic [PADDR_MAX_W-1:0] paddr;
    } phrase_t;

    // FlushPend: a flush is owed on the accumulator but could not be taken yet.
    typedef enum logic [0:0] {
        FlushNone,
        FlushPend
    } flush_st_e;

    // Force the offset to the natural alignment of the beat size.
    function automatic logic [2:0] align_off(input logic [1:0] siz, input logic [2:0] off);
        logic [2:0] res;
        case (siz)
            SIZ_BYTE: res = off;
            SIZ_WORD: res = off & 3'b110;
            default:  res = off & 3'b100;  // codes 2 and 3 are both long
        endcase
        return res;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] siz, input logic [2:0] off);
        logic [7:0] base;
        case (siz)
            SIZ_BYTE: base = 8'h01;
            SIZ_WORD: base = 8'h03;
            default:  base = 8'h0F;
        endcase
        return base << align_off(siz, off);
    endfunction

endpackage

// File: rtl/up_lane_place.sv
// up_lane_place: combinational placement of one narrow write beat into phrase lanes.
//   in_data_i     [31:0] LSB-aligned write data
//   in_siz_i      [1:0]  beat size code
//   in_off_i      [2:0]  byte offset within the phrase (aligned internally)
//   placed_data_o [63:0] data shifted into its lanes; lanes outside the beat are zero
//   lanes_o       [7:0]  byte-lane enables of the beat
module up_lane_place
    import up_pack_pkg::*;
(
    input  logic [31:0] in_data_i,
    input  logic [1:0]  in_siz_i,
    input  logic [2:0]  in_off_i,
    output logic [63:0] placed_data_o,
    output logic [7:0]  lanes_o
);

    logic [2:0]  off_aligned;
    logic [31:0] data_sized;

    always_comb begin
        off_aligned = align_off(in_siz_i, in_off_i);
        lanes_o     = lane_mask(in_siz_i, in_off_i);

        // Drop bytes above the beat size so unused lanes of the phrase stay zero.
        unique case (in_siz_i)
            SIZ_BYTE: data_sized = {24'h0, in_data_i[7:0]};
            SIZ_WORD: data_sized = {16'h0, in_data_i[15:0]};
            default:  data_sized = in_data_i;
        endcase

        placed_data_o = {32'h0, data_sized} << {off_aligned, 3'b000};
    end

endmodule

// File: rtl/up_pack.sv
// up_pack: gathers narrow writes (byte/word/long) into 64-bit phrases with byte enables.
//   sys_clk_i, reset_i      clock and synchronous active-high reset
//   in_valid_i/in_ready_o   narrow beat handshake
//   in_data_i, in_siz_i,    beat data, size, byte offset, phrase address
//   in_off_i, in_paddr_i
//   in_last_i               close the phrase holding this beat after merging
//   flush_i                 emit the partial phrase without a beat
//   out_valid_o/out_ready_i phrase handshake
//   out_data_o, out_be_o,   phrase data (disabled lanes zero), lane enables, address
//   out_paddr_o
//   busy_o                  accumulator holds at least one lane
module up_pack
    import up_pack_pkg::*;
#(
    parameter int unsigned ADDR_W     = 21,
    parameter int unsigned IDLE_FLUSH = 0
) (
    input  logic              sys_clk_i,
    input  logic              reset_i,

    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       in_data_i,
    input  logic [1:0]        in_siz_i,
    input  logic [2:0]        in_off_i,
    input  logic [ADDR_W-1:0] in_paddr_i,
    input  logic              in_last_i,
    input  logic              flush_i,

    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [63:0]       out_data_o,
    output logic [7:0]        out_be_o,
    output logic [ADDR_W-1:0] out_paddr_o,
    output logic              busy_o
);

    // Counter only needs to reach IDLE_FLUSH-1; the flush fires on the cycle that would hit it.
    localparam int unsigned CntW = (IDLE_FLUSH > 1) ? $clog2(IDLE_FLUSH) : 1;

    phrase_t   acc_q, acc_d;
    phrase_t   out_q, out_d;
    logic      out_valid_q, out_valid_d;
    flush_st_e flush_st_q, flush_st_d;
    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

    logic [63:0] placed_data;
    logic [7:0]  lanes;

    logic                   acc_busy;
    logic                   accept;
    logic                   conflict;
    logic                   idle_hit;
    logic                   flush_req;
    logic                   beat_last;
    logic                   emit;
    logic [PADDR_MAX_W-1:0] beat_paddr;
    phrase_t                merged;
    phrase_t                beat_alone;

    up_lane_place u_lane_place (
        .in_data_i    (in_data_i),
        .in_siz_i     (in_siz_i),
        .in_off_i     (in_off_i),
        .placed_data_o(placed_data),
        .lanes_o      (lanes)
    );

    always_comb begin
        acc_busy   = (acc_q.be != 8'h00);
        in_ready_o = !out_valid_q || out_ready_i;
        accept     = in_valid_i && in_ready_o;
        beat_paddr = PADDR_MAX_W'(in_paddr_i);

        conflict = acc_busy && ((acc_q.paddr != beat_paddr) || ((lanes & acc_q.be) != 8'h00));

        // Beat lanes overwrite the accumulator; empty accumulator lanes are already zero.
        merged.be    = acc_q.be | lanes;
        merged.paddr = beat_paddr;
        merged.data  = acc_q.data;
        for (int n = 0; n < 8; n++) begin
            if (lanes[n]) begin
                merged.data[8*n +: 8] = placed_data[8*n +: 8];
            end
        end

        beat_alone.data  = placed_data;
        beat_alone.be    = lanes;
        beat_alone.paddr = beat_paddr;

        idle_hit = (IDLE_FLUSH != 0) && acc_busy && !accept &&
                   (idle_cnt_q == CntW'(IDLE_FLUSH - 1));

        flush_req = flush_i || (flush_st_q == FlushPend) || idle_hit;
        // A flush owed on the accumulator closes a beat that merges into it.
        beat_last = in_last_i || flush_req;

        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !out_ready_i;
        flush_st_d  = flush_st_q;
        emit        = 1'b0;

        if (accept) begin
            if (conflict) begin
                out_d      = acc_q;
                emit       = 1'b1;
                acc_d      = beat_alone;
                // The closing beat had to start a new phrase; emit it on the next cycle.
                flush_st_d = beat_last ? FlushPend : FlushNone;
            end else if ((merged.be == 8'hFF) || beat_last) begin
                out_d      = merged;
                emit       = 1'b1;
                acc_d      = '0;
                flush_st_d = FlushNone;
            end else begin
                acc_d      = merged;
                flush_st_d = FlushNone;
            end
        end else if (flush_req && acc_busy) begin
            if (in_ready_o) begin
                out_d      = acc_q;
                emit       = 1'b1;
                acc_d      = '0;
                flush_st_d = FlushNone;
            end else begin
                flush_st_d = FlushPend;
            end
        end else if (!acc_busy) begin
            flush_st_d = FlushNone;
        end

        if (emit) begin
            out_valid_d = 1'b1;
        end

        idle_cnt_d = idle_cnt_q;
        if (accept || emit) begin
            idle_cnt_d = '0;
        end else if ((IDLE_FLUSH != 0) && acc_busy && !idle_hit) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            flush_st_q  <= FlushNone;
            idle_cnt_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            flush_st_q  <= flush_st_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q.data;
    assign out_be_o    = out_q.be;
    assign out_paddr_o = out_q.paddr[ADDR_W-1:0];
    assign busy_o      = acc_busy;

    // Address bits above ADDR_W are always zero and never leave the block.
    if (ADDR_W < PADDR_MAX_W) begin : g_paddr_hi
        logic unused_paddr_hi;
        assign unused_paddr_hi = ^out_q.paddr[PADDR_MAX_W-1:ADDR_W];
    end

endmodule
